chacha_block_reader: RTL

Byte-serial readout port for the ChaCha block core. It captures one finished 512-bit keystream block from the core over a valid/ready handshake. It then presents the block one byte at a time on the dedicated output pins, using a 4-phase req/ack handshake with the external host. It sits between the core's result register and `uo_out`/`uio_out` in the top level, and is the read-side counterpart of the byte-wide state loader.

---
 rtl/chacha_block_reader_if.sv | 34 +++
 rtl/chacha_block_reader.sv | 109 ++++++++++
 2 files changed

// File: rtl/chacha_block_reader_if.sv
// Handshake bundle for the ChaCha block reader: block capture from the core
// and byte-serial readout to the host.
interface chacha_block_reader_if;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         rd_ack;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_last;
    logic         busy;

    modport master (
        output blk_data,
        output blk_valid,
        output rd_ack,
        input  blk_ready,
        input  byte_out,
        input  byte_valid,
        input  byte_last,
        input  busy
    );

    modport slave (
        input  blk_data,
        input  blk_valid,
        input  rd_ack,
        output blk_ready,
        output byte_out,
        output byte_valid,
        output byte_last,
        output busy
    );
endinterface

// File: rtl/chacha_block_reader.sv
// Byte-serial readout of one 512-bit ChaCha block over a 4-phase req/ack handshake.
// Optional 2-flop rd_ack synchronizer enabled by defining CHACHA_READER_SYNC_EN.
module chacha_block_reader (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    chacha_block_reader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [511:0] sh_q, sh_d;
    logic [5:0]   idx_q, idx_d;
    logic         ack_s;

`ifdef CHACHA_READER_SYNC_EN
    logic ack_meta_q, ack_meta_d;
    logic ack_sync_q, ack_sync_d;

    always_comb begin
        ack_meta_d = ack_meta_q;
        ack_sync_d = ack_sync_q;
        if (ena) begin
            ack_meta_d = bus.rd_ack;
            ack_sync_d = ack_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= ack_meta_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign ack_s = ack_sync_q;
`else
    assign ack_s = bus.rd_ack;
`endif

    // The shift and index advance happen on the RELEASE exit edge, so the next
    // byte appears together with the rising byte_valid.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (bus.blk_valid) begin
                        sh_d    = bus.blk_data;
                        idx_d   = 6'd0;
                        state_d = ARM;
                    end
                end
                ARM: begin
                    if (!ack_s) begin
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_s) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        sh_d = {8'h00, sh_q[511:8]};
                        if (idx_q == 6'd63) begin
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            state_d = PRESENT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.blk_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.byte_out   = sh_q[7:0];
    assign bus.byte_valid = (state_q == PRESENT);
    assign bus.byte_last  = (state_q == PRESENT) && (idx_q == 6'd63);

endmodule
